hydra_port_scheduler: RTL and testbench

- Per-output-port dequeue scheduler for the hydra switch.
- Tracks how many complete packets are queued in each of 8 priority queues of one output port.
- On a downstream ready request, selects the next priority queue to read, using strict priority or weighted round robin (WRR) as set by wrr_enable.
- Issues one grant per packet and holds off further grants until the read datapath reports rd_eop; instantiated 16× in hydra, one per port.

---
 rtl/hydra_pkg.sv | 24 ++
 rtl/hydra_port_scheduler_if.sv | 32 +++
 rtl/hydra_pri_select.sv | 28 ++
 rtl/hydra_port_scheduler.sv | 174 +++++++++++++++++
 tb/tb_hydra_port_scheduler.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hydra_pkg.sv
// Shared types and constants for the hydra port scheduler.
// WRR weight: queue 0 gets the largest share.
package hydra_pkg;

  localparam int NUM_PRI = 8;
  localparam int PRI_W   = $clog2(NUM_PRI);
  localparam int CNT_W   = 10;
  localparam int CRD_W   = PRI_W + 1;

  typedef logic [PRI_W-1:0] pri_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CRD_W-1:0] crd_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT_EOP
  } state_e;

  function automatic crd_t weight(pri_t p);
    return crd_t'(NUM_PRI) - crd_t'(p);
  endfunction

endpackage

// File: rtl/hydra_port_scheduler_if.sv
// Scheduler request/grant bundle.
// master drives enqueue/ready/eop, slave returns grants and status.
interface hydra_port_scheduler_if;
  import hydra_pkg::*;

  logic               wrr_enable;
  logic               enq_vld;
  pri_t               enq_pri;
  logic               ready;
  logic               rd_eop;
  logic               sched_vld;
  pri_t               sched_pri;
  logic               busy;
  logic [NUM_PRI-1:0] q_nonempty;
  logic               ovf_err;
  logic               eop_err;

  modport master (
    output wrr_enable, enq_vld, enq_pri,
    output ready, rd_eop,
    input  sched_vld, sched_pri, busy,
    input  q_nonempty, ovf_err, eop_err
  );

  modport slave (
    input  wrr_enable, enq_vld, enq_pri,
    input  ready, rd_eop,
    output sched_vld, sched_pri, busy,
    output q_nonempty, ovf_err, eop_err
  );

endinterface

// File: rtl/hydra_pri_select.sv
// Queue picker: lowest nonempty index, or first
// nonempty searching circularly from ptr+1.
import hydra_pkg::*;

module hydra_pri_select (
  input  logic [NUM_PRI-1:0] nonempty,
  input  pri_t               ptr,
  input  logic               circ,
  output pri_t               idx,
  output logic               found
);

  always_comb begin
    idx   = '0;
    found = |nonempty;
    if (circ) begin
      // offset NUM_PRI wraps to ptr itself, checked last
      for (int k = NUM_PRI; k >= 1; k--) begin
        if (nonempty[ptr + pri_t'(k)]) idx = ptr + pri_t'(k);
      end
    end else begin
      for (int k = NUM_PRI - 1; k >= 0; k--) begin
        if (nonempty[k]) idx = pri_t'(k);
      end
    end
  end

endmodule

// File: rtl/hydra_port_scheduler.sv
// Per-port dequeue scheduler: packet counters per priority,
// strict or WRR selection, one grant per packet until rd_eop.
import hydra_pkg::*;

module hydra_port_scheduler (
  input  logic                  clk,
  input  logic                  rst_n,
  hydra_port_scheduler_if.slave bus
);

  state_e state_q, state_d;
  cnt_t   cnt_q [NUM_PRI];
  cnt_t   cnt_d [NUM_PRI];
  logic   pend_q, pend_d;
  pri_t   sel_q, sel_d;
  logic   mode_q, mode_d;
  logic   last_q, last_d;
  pri_t   ptr_q, ptr_d;
  crd_t   crd_q, crd_d;
  logic   vld_q, vld_d;
  pri_t   spri_q, spri_d;
  logic   busy_q, busy_d;
  logic   ovf_q, ovf_d;
  logic   eop_q, eop_d;

  logic [NUM_PRI-1:0] nonempty;
  logic wrr_chg;
  pri_t eff_ptr;
  crd_t eff_crd;
  crd_t crd_dec;
  pri_t pick;
  logic found;
  logic take;

  always_comb begin
    for (int p = 0; p < NUM_PRI; p++) begin
      nonempty[p] = cnt_q[p] != '0;
    end
  end

  // a mode flip restarts the WRR round before selecting
  always_comb begin
    wrr_chg = (state_q == IDLE) && (bus.wrr_enable != last_q);
    eff_ptr = wrr_chg ? '0 : ptr_q;
    eff_crd = wrr_chg ? weight('0) : crd_q;
  end

  hydra_pri_select u_sel (
    .nonempty (nonempty),
    .ptr      (eff_ptr),
    .circ     (bus.wrr_enable),
    .idx      (pick),
    .found    (found)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    sel_d   = sel_q;
    mode_d  = mode_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    crd_d   = crd_q;
    vld_d   = 1'b0;
    spri_d  = spri_q;
    busy_d  = 1'b0;
    ovf_d   = ovf_q;
    eop_d   = eop_q;
    take    = 1'b0;
    crd_dec = crd_q - crd_t'(1);

    for (int p = 0; p < NUM_PRI; p++) begin
      if (bus.enq_vld && bus.enq_pri == pri_t'(p) &&
          !(state_q == GRANT && sel_q == pri_t'(p))) begin
        if (cnt_q[p] == '1) ovf_d = 1'b1;
        else cnt_d[p] = cnt_q[p] + cnt_t'(1);
      end else if (!(bus.enq_vld && bus.enq_pri == pri_t'(p)) &&
                   state_q == GRANT && sel_q == pri_t'(p)) begin
        cnt_d[p] = cnt_q[p] - cnt_t'(1);
      end
    end

    unique case (state_q)
      IDLE: begin
        if (wrr_chg) begin
          ptr_d  = eff_ptr;
          crd_d  = eff_crd;
          last_d = bus.wrr_enable;
        end
        if ((pend_q || bus.ready) && found) begin
          take    = 1'b1;
          state_d = GRANT;
          mode_d  = bus.wrr_enable;
          if (bus.wrr_enable && nonempty[eff_ptr] &&
              eff_crd != '0) begin
            sel_d = eff_ptr;
          end else begin
            sel_d = pick;
            if (bus.wrr_enable) begin
              ptr_d = pick;
              crd_d = weight(pick);
            end
          end
        end
      end
      GRANT: begin
        vld_d   = 1'b1;
        spri_d  = sel_q;
        busy_d  = 1'b1;
        state_d = WAIT_EOP;
        if (mode_q) begin
          if (crd_dec == '0 || cnt_d[sel_q] == '0) begin
            ptr_d = ptr_q + pri_t'(1);
            crd_d = weight(ptr_q + pri_t'(1));
          end else begin
            crd_d = crd_dec;
          end
        end
      end
      WAIT_EOP: begin
        busy_d = 1'b1;
        if (bus.rd_eop) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    pend_d = take ? 1'b0 : (pend_q | bus.ready);
    eop_d  = eop_q | (bus.rd_eop && state_q != WAIT_EOP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int p = 0; p < NUM_PRI; p++) cnt_q[p] <= '0;
      pend_q  <= 1'b0;
      sel_q   <= '0;
      mode_q  <= 1'b0;
      last_q  <= 1'b0;
      ptr_q   <= '0;
      crd_q   <= weight('0);
      vld_q   <= 1'b0;
      spri_q  <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      eop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sel_q   <= sel_d;
      mode_q  <= mode_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      crd_q   <= crd_d;
      vld_q   <= vld_d;
      spri_q  <= spri_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      eop_q   <= eop_d;
    end
  end

  assign bus.sched_vld  = vld_q;
  assign bus.sched_pri  = spri_q;
  assign bus.busy       = busy_q;
  assign bus.q_nonempty = nonempty;
  assign bus.ovf_err    = ovf_q;
  assign bus.eop_err    = eop_q;

endmodule

// File: tb/tb_hydra_port_scheduler.sv
// Bench for hydra_port_scheduler: hand sequences, a strict-priority
// vector table and a randomized run against a packet-level model.
module tb_hydra_port_scheduler;
  import hydra_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hydra_port_scheduler_if bus ();

  hydra_port_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] mask;
    int         first;
    logic [7:0] ne_after;
  } vec_t;

  vec_t tbl [5];
  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt [NUM_PRI];
  int m_ptr;
  int m_crd;
  bit m_last;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int p = 0; p < NUM_PRI; p++) m_cnt[p] = 0;
    m_ptr  = 0;
    m_crd  = NUM_PRI;
    m_last = 1'b0;
  endfunction

  function automatic int m_total();
    int t = 0;
    for (int p = 0; p < NUM_PRI; p++) t += m_cnt[p];
    return t;
  endfunction

  function automatic logic [7:0] m_mask();
    logic [7:0] m = '0;
    for (int p = 0; p < NUM_PRI; p++) m[p] = (m_cnt[p] != 0);
    return m;
  endfunction

  // which queue the next grant should serve, from the queueing rules
  function automatic int model_pick(bit wrr);
    int sel = -1;
    if (wrr != m_last) begin
      m_ptr  = 0;
      m_crd  = NUM_PRI;
      m_last = wrr;
    end
    if (!wrr) begin
      for (int p = NUM_PRI - 1; p >= 0; p--) if (m_cnt[p] > 0) sel = p;
      if (sel >= 0) m_cnt[sel]--;
      return sel;
    end
    if (m_cnt[m_ptr] > 0 && m_crd > 0) begin
      sel = m_ptr;
    end else begin
      for (int k = 1; k <= NUM_PRI; k++) begin
        int q;
        q = (m_ptr + k) % NUM_PRI;
        if (m_cnt[q] > 0) begin
          sel   = q;
          m_ptr = q;
          m_crd = NUM_PRI - q;
          break;
        end
      end
    end
    if (sel < 0) return sel;
    m_cnt[sel]--;
    m_crd--;
    if (m_crd == 0 || m_cnt[m_ptr] == 0) begin
      m_ptr = (m_ptr + 1) % NUM_PRI;
      m_crd = NUM_PRI - m_ptr;
    end
    return sel;
  endfunction

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.wrr_enable = 1'b0;
    bus.enq_vld    = 1'b0;
    bus.enq_pri    = '0;
    bus.ready      = 1'b0;
    bus.rd_eop     = 1'b0;
    m_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic enq(input int p);
    bus.enq_vld = 1'b1;
    bus.enq_pri = pri_t'(p);
    tick();
    bus.enq_vld = 1'b0;
    if (m_cnt[p] < (1 << CNT_W) - 1) m_cnt[p]++;
  endtask

  task automatic eop();
    bus.rd_eop = 1'b1;
    tick();
    bus.rd_eop = 1'b0;
  endtask

  // ready from IDLE: grant is visible after the second edge
  task automatic request(input bit wrr, output int got, output int lat);
    int exp;
    bus.wrr_enable = wrr;
    exp = model_pick(wrr);
    bus.ready = 1'b1;
    lat = 0;
    got = -1;
    while (lat < 20) begin
      tick();
      bus.ready = 1'b0;
      lat++;
      if (bus.sched_vld === 1'b1) begin
        got = int'(bus.sched_pri);
        break;
      end
    end
    check("grant_pri", got, exp);
    check("grant_lat", lat, 2);
  endtask

  task automatic drain(input bit wrr);
    int got, lat, guard;
    guard = 0;
    while (m_total() > 0 && guard < 2000) begin
      request(wrr, got, lat);
      eop();
      guard++;
    end
    check("drain_empty", bus.q_nonempty, 0);
  endtask

  initial begin
    int got, lat, n, extra, exp;
    bit mode;
    int exp_ord [30];

    tbl[0] = '{8'h24, 2, 8'h20};
    tbl[1] = '{8'h80, 7, 8'h00};
    tbl[2] = '{8'hFF, 0, 8'hFE};
    tbl[3] = '{8'h18, 3, 8'h10};
    tbl[4] = '{8'h41, 0, 8'h40};
    for (int i = 0; i < 30; i++) begin
      exp_ord[i] = (i < 8) ? 0 : (i < 15) ? 1 : (i < 23) ? 0 : 1;
    end

    do_reset();
    check("rst_sched_vld", bus.sched_vld, 0);
    check("rst_sched_pri", bus.sched_pri, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_q_nonempty", bus.q_nonempty, 0);
    check("rst_ovf_err", bus.ovf_err, 0);
    check("rst_eop_err", bus.eop_err, 0);

    enq(5);
    enq(2);
    enq(7);
    check("strict_ne", bus.q_nonempty, 8'hA4);
    request(0, got, lat);
    check("strict_g0", got, 2);
    check("strict_busy", bus.busy, 1);
    eop();
    check("strict_busy_clr", bus.busy, 0);
    request(0, got, lat);
    check("strict_g1", got, 5);
    eop();
    request(0, got, lat);
    check("strict_g2", got, 7);
    eop();
    check("strict_ne_end", bus.q_nonempty, 0);

    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < 8; b++) if (tbl[i].mask[b]) enq(b);
      request(0, got, lat);
      check("tbl_first", got, tbl[i].first);
      check("tbl_ne", bus.q_nonempty, tbl[i].ne_after);
      eop();
      drain(0);
    end

    enq(1);
    enq(1);
    enq(1);
    request(0, got, lat);
    repeat (3) begin
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;
      tick();
    end
    check("bp_busy", bus.busy, 1);
    check("bp_no_vld", bus.sched_vld, 0);
    exp = model_pick(0);
    bus.rd_eop = 1'b1;
    n = 0;
    got = -1;
    while (n < 20) begin
      tick();
      bus.rd_eop = 1'b0;
      n++;
      if (bus.sched_vld === 1'b1) begin
        got = int'(bus.sched_pri);
        break;
      end
    end
    check("bp_regrant_lat", n, 3);
    check("bp_regrant_pri", got, exp);
    eop();
    extra = 0;
    repeat (10) begin
      tick();
      if (bus.sched_vld === 1'b1) extra++;
    end
    check("bp_extra", extra, 0);
    check("bp_ne", bus.q_nonempty, 8'h02);
    drain(0);

    enq(3);
    bus.ready = 1'b1;
    tick();
    bus.ready   = 1'b0;
    bus.enq_vld = 1'b1;
    bus.enq_pri = 3'd3;
    tick();
    bus.enq_vld = 1'b0;
    check("sim_vld", bus.sched_vld, 1);
    check("sim_pri", bus.sched_pri, 3);
    check("sim_ne", bus.q_nonempty, 8'h08);
    eop();
    check("sim_ne_idle", bus.q_nonempty, 8'h08);
    request(0, got, lat);
    check("sim_second", got, 3);
    eop();
    check("sim_ne_end", bus.q_nonempty, 0);

    for (int i = 0; i < 20; i++) begin
      enq(0);
      enq(1);
    end
    for (int i = 0; i < 30; i++) begin
      request(1, got, lat);
      check("wrr_order", got, exp_ord[i]);
      eop();
    end
    drain(1);

    check("eop_err_pre", bus.eop_err, 0);
    eop();
    check("eop_err_idle", bus.eop_err, 1);
    check("eop_err_busy", bus.busy, 0);
    enq(6);
    request(0, got, lat);
    check("eop_err_state", got, 6);
    eop();

    do_reset();
    repeat (1023) enq(4);
    check("sat_ovf_pre", bus.ovf_err, 0);
    check("sat_ne", bus.q_nonempty, 8'h10);
    enq(4);
    check("sat_ovf", bus.ovf_err, 1);
    request(0, got, lat);
    check("sat_grant", got, 4);

    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vld", bus.sched_vld, 0);
    check("arst_pri", bus.sched_pri, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_ne", bus.q_nonempty, 0);
    check("arst_ovf", bus.ovf_err, 0);
    m_reset();
    tick();
    rst_n = 1'b1;
    tick();
    eop();
    check("arst_late_eop", bus.eop_err, 1);
    check("arst_late_busy", bus.busy, 0);

    do_reset();
    mode = 1'b0;
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 5) == 0) mode = ~mode;
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 1) == 0) enq($urandom_range(0, 2));
        else enq($urandom_range(0, 7));
      end
      if (m_total() > 0) begin
        request(mode, got, lat);
        repeat ($urandom_range(0, 3)) tick();
        check("rnd_busy", bus.busy, 1);
        eop();
      end
      check("rnd_ne", bus.q_nonempty, m_mask());
    end
    drain(mode);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
